dffrs_bank: RTL and testbench

Parametrised multi-bit successor to the single-bit set/reset flip-flop cell. It holds WIDTH bits with per-bit active-low set and clear, a load enable, a serial scan-shift mode with a shift-complete pulse, and a registered change-detect flag. All behaviour is synchronous to one clock. It sits in the standard-cell wrapper layer and replaces ad-hoc arrays of single-bit set/reset flops in control-register and test-access logic.

---
 rtl/dffrs_pkg.sv | 16 +
 rtl/dffrs_force_bit.sv | 16 +
 rtl/dffrs_bank.sv | 90 +++++++++
 tb/tb_dffrs_bank.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dffrs_pkg.sv
// Shared types and helpers for the dffrs_bank set/reset register bank.
// Holds the base-value select encoding and the shift-counter width derivation.
package dffrs_pkg;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } dffrs_mode_e;

   // Counter must be able to represent WIDTH itself, hence WIDTH+1.
   function automatic int calc_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/dffrs_force_bit.sv
// One bit of the bank: applies the active-low clear/set forces on top of the
// base value and produces the complement output with the dual-force exception.
module dffrs_force_bit (
   input  logic base_i,
   input  logic q_i,
   input  logic sn_i,
   input  logic rn_i,
   output logic d_o,
   output logic qn_o
);

   // Clear dominates set; ternaries keep X on a force pin visible in simulation.
   assign d_o  = !rn_i ? 1'b0 : (!sn_i ? 1'b1 : base_i);
   assign qn_o = (!sn_i && !rn_i) ? 1'b0 : ~q_i;

endmodule

// File: rtl/dffrs_bank.sv
// WIDTH-bit register bank with per-bit set/clear, parallel load, scan shift
// toward the MSB with a shift-complete pulse, and a registered change flag.
module dffrs_bank
   import dffrs_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             CK,
   input  logic             RST,
   input  logic [WIDTH-1:0] D,
   input  logic             EN,
   input  logic [WIDTH-1:0] SN,
   input  logic [WIDTH-1:0] RN,
   input  logic             SE,
   input  logic             SI,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] QN,
   output logic             SO,
   output logic             SDONE,
   output logic             CHG
);

   localparam int               CNT_W    = calc_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] q_q, q_d, base_d, qn_w;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sdone_q, sdone_d;
   logic             chg_q, chg_d;
   dffrs_mode_e      mode;

   assign mode = SE ? SHIFT : (EN ? LOAD : HOLD);

   always_comb begin
      base_d = q_q;
      case (mode)
         SHIFT:   base_d = {q_q[WIDTH-2:0], SI};
         LOAD:    base_d = D;
         HOLD:    base_d = q_q;
         default: base_d = {WIDTH{1'bx}};
      endcase
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dffrs_force_bit u_force (
         .base_i (base_d[i]),
         .q_i    (q_q[i]),
         .sn_i   (SN[i]),
         .rn_i   (RN[i]),
         .d_o    (q_d[i]),
         .qn_o   (qn_w[i])
      );
   end

   // Counter tracks consecutive shift edges only; forces never touch it.
   always_comb begin
      cnt_d   = '0;
      sdone_d = 1'b0;
      if (SE) begin
         if (cnt_q == CNT_LAST) begin
            sdone_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      chg_d = (q_d != q_q);
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         q_q     <= RESET_VAL;
         cnt_q   <= '0;
         sdone_q <= 1'b0;
         chg_q   <= 1'b0;
      end else begin
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         sdone_q <= sdone_d;
         chg_q   <= chg_d;
      end
   end

   assign Q     = q_q;
   assign QN    = qn_w;
   assign SO    = q_q[WIDTH-1];
   assign SDONE = sdone_q;
   assign CHG   = chg_q;

endmodule

// File: tb/tb_dffrs_bank.sv
// Bench for dffrs_bank (WIDTH=8, RESET_VAL=8'hA5): directed scenarios plus a
// randomized run, all checked against an arithmetic reference model.
module tb_dffrs_bank;

   localparam int         W       = 8;
   localparam logic [7:0] RST_VAL = 8'hA5;

   logic       CK = 1'b0;
   logic       RST, EN, SE, SI;
   logic [7:0] D, SN, RN;
   logic [7:0] Q, QN;
   logic       SO, SDONE, CHG;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [7:0] m_q;
   int         m_run;
   logic       m_sdone, m_chg;

   dffrs_bank #(.WIDTH(W), .RESET_VAL(RST_VAL)) dut (
      .CK(CK), .RST(RST), .D(D), .EN(EN), .SN(SN), .RN(RN), .SE(SE), .SI(SI),
      .Q(Q), .QN(QN), .SO(SO), .SDONE(SDONE), .CHG(CHG)
   );

   always #5 CK = ~CK;

   // Advance the model by one edge using the current inputs, then wait for the
   // DUT edge and settle 1 time unit past it.
   task automatic edge_step();
      logic [7:0] base, nq;
      if (RST) begin
         nq      = RST_VAL;
         m_run   = 0;
         m_sdone = 1'b0;
         m_chg   = 1'b0;
      end else begin
         if (SE)      base = 8'((m_q * 2) + SI);
         else if (EN) base = D;
         else         base = m_q;
         nq      = (base | ~SN) & RN;
         m_chg   = (nq != m_q);
         m_run   = SE ? m_run + 1 : 0;
         m_sdone = SE && (m_run % W == 0);
      end
      m_q = nq;
      @(posedge CK);
      #1;
   endtask

   task automatic idle_inputs();
      RST = 1'b0; EN = 1'b0; SE = 1'b0; SI = 1'b0;
      D = 8'h00; SN = 8'hFF; RN = 8'hFF;
   endtask

   task automatic test_reset();
      idle_inputs();
      RST = 1'b1; EN = 1'b1; D = 8'hFF;
      edge_step();
      checks++;
      if (Q !== 8'hA5) begin failures++; $display("FAIL reset_q got=%h exp=%h", Q, 8'hA5); end
      checks++;
      if (SDONE !== 1'b0 || CHG !== 1'b0) begin
         failures++; $display("FAIL reset_flags got sdone=%b chg=%b exp=0/0", SDONE, CHG);
      end
      RST = 1'b0;
      edge_step();
      checks++;
      if (Q !== 8'hFF || Q !== m_q) begin failures++; $display("FAIL reset_release_q got=%h exp=%h", Q, m_q); end
      checks++;
      if (CHG !== 1'b1) begin failures++; $display("FAIL reset_release_chg got=%b exp=1", CHG); end
   endtask

   task automatic test_force();
      idle_inputs();
      EN = 1'b1; D = 8'h00;
      edge_step();
      EN = 1'b0; SN = 8'hF0; RN = 8'hFC;
      edge_step();
      checks++;
      if (Q !== 8'h0C || Q !== m_q) begin failures++; $display("FAIL force_q got=%h exp=%h", Q, 8'h0C); end
      checks++;
      if (QN[1:0] !== 2'b00) begin failures++; $display("FAIL force_dual_qn got=%b exp=00", QN[1:0]); end
      checks++;
      if (QN !== (~m_q & (SN | RN))) begin
         failures++; $display("FAIL force_qn got=%h exp=%h", QN, ~m_q & (SN | RN));
      end
      checks++;
      if (CHG !== m_chg || CHG !== 1'b1) begin failures++; $display("FAIL force_chg got=%b exp=1", CHG); end
      idle_inputs();
      edge_step();
   endtask

   task automatic test_force_shift();
      idle_inputs();
      EN = 1'b1; D = 8'h81;
      edge_step();
      EN = 1'b0; SE = 1'b1; SI = 1'b1; RN = 8'hFE;
      edge_step();
      checks++;
      if (Q !== 8'h02 || Q !== m_q) begin failures++; $display("FAIL force_shift_q got=%h exp=%h", Q, 8'h02); end
      RN = 8'hFF;
      for (int i = 1; i < W; i++) begin
         SI = 1'($urandom_range(0, 1));
         edge_step();
         checks++;
         if (SDONE !== m_sdone) begin
            failures++; $display("FAIL force_shift_sdone edge=%0d got=%b exp=%b", i, SDONE, m_sdone);
         end
      end
      checks++;
      if (SDONE !== 1'b1) begin failures++; $display("FAIL force_shift_count got=%b exp=1", SDONE); end
      idle_inputs();
      edge_step();
   endtask

   task automatic test_scan();
      int pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
      idle_inputs();
      SE = 1'b1;
      for (int i = 0; i < W; i++) begin
         SI = 1'(pat[i]);
         edge_step();
         checks++;
         if (SO !== Q[7] || SO !== m_q[7]) begin failures++; $display("FAIL scan_so edge=%0d got=%b exp=%b", i, SO, m_q[7]); end
         checks++;
         if (SDONE !== (i == W - 1)) begin
            failures++; $display("FAIL scan_sdone edge=%0d got=%b exp=%b", i, SDONE, (i == W - 1));
         end
      end
      checks++;
      if (Q !== 8'hB2 || Q !== m_q) begin failures++; $display("FAIL scan_q got=%h exp=%h", Q, 8'hB2); end
      SE = 1'b0;
      edge_step();
      checks++;
      if (SDONE !== 1'b0) begin failures++; $display("FAIL scan_sdone_drop got=%b exp=0", SDONE); end
   endtask

   task automatic test_scan_interrupt();
      int pulses;
      idle_inputs();
      pulses = 0;
      SE = 1'b1;
      for (int i = 0; i < 5; i++) begin
         SI = 1'($urandom_range(0, 1));
         edge_step();
         if (SDONE === 1'b1) pulses++;
      end
      SE = 1'b0;
      edge_step();
      if (SDONE === 1'b1) pulses++;
      checks++;
      if (pulses != 0) begin failures++; $display("FAIL interrupt_early pulses=%0d exp=0", pulses); end
      SE = 1'b1;
      for (int i = 0; i < W; i++) begin
         SI = 1'($urandom_range(0, 1));
         edge_step();
         checks++;
         if (SDONE !== m_sdone || SDONE !== (i == W - 1)) begin
            failures++; $display("FAIL interrupt_restart edge=%0d got=%b exp=%b", i, SDONE, (i == W - 1));
         end
      end
      SE = 1'b0;
      edge_step();
      // Reset four edges into an eight-edge shift
      SE = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin edge_step(); if (SDONE === 1'b1) pulses++; end
      RST = 1'b1;
      edge_step();
      checks++;
      if (SDONE !== 1'b0 || Q !== RST_VAL) begin
         failures++; $display("FAIL interrupt_reset got sdone=%b q=%h exp=0/%h", SDONE, Q, RST_VAL);
      end
      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin edge_step(); if (SDONE === 1'b1) pulses++; end
      checks++;
      if (pulses != 0) begin failures++; $display("FAIL interrupt_reset_suppress pulses=%0d exp=0", pulses); end
      for (int i = 0; i < 4; i++) edge_step();
      checks++;
      if (SDONE !== 1'b1 || SDONE !== m_sdone) begin
         failures++; $display("FAIL interrupt_after_reset got=%b exp=1", SDONE);
      end
      idle_inputs();
      edge_step();
   endtask

   task automatic test_hold_chg();
      logic [7:0] held;
      idle_inputs();
      held = m_q;
      for (int i = 0; i < 4; i++) begin
         edge_step();
         checks++;
         if (Q !== held || CHG !== 1'b0) begin
            failures++; $display("FAIL hold edge=%0d got q=%h chg=%b exp q=%h chg=0", i, Q, CHG, held);
         end
      end
      EN = 1'b1; D = held;
      edge_step();
      checks++;
      if (Q !== held || CHG !== 1'b0) begin
         failures++; $display("FAIL hold_same_load got q=%h chg=%b exp q=%h chg=0", Q, CHG, held);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         RST = ($urandom_range(0, 39) == 0);
         EN  = 1'($urandom_range(0, 1));
         SE  = ($urandom_range(0, 9) < 7);
         SI  = 1'($urandom_range(0, 1));
         D   = 8'($urandom);
         SN  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         RN  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         edge_step();
         checks++;
         if (Q !== m_q) begin failures++; $display("FAIL rand_q cyc=%0d got=%h exp=%h", i, Q, m_q); end
         checks++;
         if (QN !== (~m_q & (SN | RN))) begin
            failures++; $display("FAIL rand_qn cyc=%0d got=%h exp=%h", i, QN, ~m_q & (SN | RN));
         end
         checks++;
         if (SO !== m_q[7]) begin failures++; $display("FAIL rand_so cyc=%0d got=%b exp=%b", i, SO, m_q[7]); end
         checks++;
         if (SDONE !== m_sdone) begin failures++; $display("FAIL rand_sdone cyc=%0d got=%b exp=%b", i, SDONE, m_sdone); end
         checks++;
         if (CHG !== m_chg) begin failures++; $display("FAIL rand_chg cyc=%0d got=%b exp=%b", i, CHG, m_chg); end
      end
   endtask

   initial begin
      m_q = 8'h00; m_run = 0; m_sdone = 1'b0; m_chg = 1'b0;
      idle_inputs();
      @(negedge CK);
      test_reset();
      test_force();
      test_force_shift();
      test_scan();
      test_scan_interrupt();
      test_hold_chg();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
